// File: rtl/pwm_pkg.sv
// pwm_pkg: widths, limits and duty FSM states shared by
// the PWM block and its duty controller.
package pwm_pkg;

  localparam int DUTY_W       = 4;
  localparam int PHASE_W      = 3;
  localparam int DUTY_MAX_DEF = 8;

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } duty_st_t;

  // Step up by one, clamped at lim.
  function automatic logic [DUTY_W-1:0] duty_inc(
    input logic [DUTY_W-1:0] d,
    input logic [DUTY_W-1:0] lim
  );
    return (d >= lim) ? lim : d + DUTY_W'(1);
  endfunction

  // Step down by one, clamped at zero.
  function automatic logic [DUTY_W-1:0] duty_dec(
    input logic [DUTY_W-1:0] d
  );
    return (d == '0) ? '0 : d - DUTY_W'(1);
  endfunction

endpackage

// File: rtl/pwm_duty_ctrl_debounce.sv
// btn_debounce: 2-flop sync, stable-level debounce and a
// one-cycle press pulse on the accepted rising level.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYC - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  // Bring the raw button into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after it has held long enough;
  // any return to the old level restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
        r_press <= r_sync2;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/pwm_duty_ctrl.sv
// pwm_duty_ctrl: produces the PWM duty from push-buttons or
// a breathing ramp, changing it only at period boundaries.
module pwm_duty_ctrl
  import pwm_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 16,
  parameter int BREATH_DIV   = 4,
  parameter int DUTY_MAX     = DUTY_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_up,
  input  logic              btn_dn,
  input  logic              mode,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_upd
);

  localparam int STEP_W = $clog2(BREATH_DIV) + 1;
  localparam logic [STEP_W-1:0] STEP_LAST =
    STEP_W'(BREATH_DIV - 1);
  localparam logic [DUTY_W-1:0] D_MAX = DUTY_W'(DUTY_MAX);

  logic               w_press_up;
  logic               w_press_dn;
  logic               r_mode_s1;
  logic               r_mode_s2;
  logic [PHASE_W-1:0] r_phase;
  logic               w_bound;
  logic               r_pend_up;
  logic               r_pend_dn;
  logic               w_req_up;
  logic               w_req_dn;
  duty_st_t           r_state;
  duty_st_t           w_state_nxt;
  logic [STEP_W-1:0]  r_step;
  logic [STEP_W-1:0]  w_step_nxt;
  logic               w_step_fire;
  logic [DUTY_W-1:0]  r_duty;
  logic [DUTY_W-1:0]  w_duty_nxt;
  logic [DUTY_W-1:0]  w_duty_inc;
  logic [DUTY_W-1:0]  w_duty_dec;
  logic               r_upd;

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_db_up (
    .clk    (clk),
    .rst    (rst),
    .i_btn  (btn_up),
    .o_press(w_press_up)
  );

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_db_dn (
    .clk    (clk),
    .rst    (rst),
    .i_btn  (btn_dn),
    .o_press(w_press_dn)
  );

  // Mode is a slow switch; synchronize only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode_s1 <= 1'b0;
      r_mode_s2 <= 1'b0;
    end else begin
      r_mode_s1 <= mode;
      r_mode_s2 <= r_mode_s1;
    end
  end

  // Free-running phase, in lockstep with the PWM counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= '0;
    end else begin
      r_phase <= r_phase + PHASE_W'(1);
    end
  end

  assign w_bound = &r_phase;

  // A press landing on the boundary cycle still counts now.
  assign w_req_up = r_pend_up | w_press_up;
  assign w_req_dn = r_pend_dn | w_press_dn;

  // Hold presses until the next boundary, then drop them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_up <= 1'b0;
      r_pend_dn <= 1'b0;
    end else if (w_bound) begin
      r_pend_up <= 1'b0;
      r_pend_dn <= 1'b0;
    end else begin
      r_pend_up <= w_req_up;
      r_pend_dn <= w_req_dn;
    end
  end

  assign w_duty_inc  = duty_inc(r_duty, D_MAX);
  assign w_duty_dec  = duty_dec(r_duty);
  assign w_step_fire = w_bound && (r_step == STEP_LAST);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= MANUAL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: mode selects manual vs ramp; the ramp
  // turns around on the step that hits either end.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      MANUAL: begin
        if (r_mode_s2) begin
          w_state_nxt = RISE;
        end
      end
      RISE: begin
        if (!r_mode_s2) begin
          w_state_nxt = MANUAL;
        end else if (w_step_fire && w_duty_inc == D_MAX) begin
          w_state_nxt = FALL;
        end
      end
      FALL: begin
        if (!r_mode_s2) begin
          w_state_nxt = MANUAL;
        end else if (w_step_fire && w_duty_dec == '0) begin
          w_state_nxt = RISE;
        end
      end
      default: begin
        w_state_nxt = MANUAL;
      end
    endcase
  end

  // Outputs: next duty and step count. Nothing moves on
  // the cycle the FSM leaves a state.
  always_comb begin
    w_duty_nxt = r_duty;
    w_step_nxt = r_step;
    unique case (r_state)
      MANUAL: begin
        if (!r_mode_s2 && w_bound) begin
          unique case ({w_req_up, w_req_dn})
            2'b10:   w_duty_nxt = w_duty_inc;
            2'b01:   w_duty_nxt = w_duty_dec;
            default: w_duty_nxt = r_duty;
          endcase
        end
      end
      RISE, FALL: begin
        if (r_mode_s2 && w_bound) begin
          if (w_step_fire) begin
            w_step_nxt = '0;
            w_duty_nxt = (r_state == RISE) ? w_duty_inc
                                           : w_duty_dec;
          end else begin
            w_step_nxt = r_step + STEP_W'(1);
          end
        end
      end
      default: begin
        w_duty_nxt = r_duty;
      end
    endcase
    if (w_state_nxt != r_state) begin
      w_step_nxt = '0;
    end
  end

  // Duty and step registers; pulse only on a real change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_duty <= '0;
      r_step <= '0;
      r_upd  <= 1'b0;
    end else begin
      r_duty <= w_duty_nxt;
      r_step <= w_step_nxt;
      r_upd  <= (w_duty_nxt != r_duty);
    end
  end

  assign duty     = r_duty;
  assign duty_upd = r_upd;

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// tb_pwm_duty_ctrl: directed steps with hand-derived
// cycle-exact expectations for the duty controller.
module tb_pwm_duty_ctrl;
  import pwm_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              btn_up = 1'b0;
  logic              btn_dn = 1'b0;
  logic              mode = 1'b0;
  logic [DUTY_W-1:0] duty;
  logic              duty_upd;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_upd = 0;
  int snap = 0;

  pwm_duty_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .btn_up  (btn_up),
    .btn_dn  (btn_dn),
    .mode    (mode),
    .duty    (duty),
    .duty_upd(duty_upd)
  );

  always #5 clk = ~clk;

  // Edges since reset release; edge k with k%8==0 is a boundary.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Count duty_upd pulses.
  always @(negedge clk) begin
    if (duty_upd === 1'b1) n_upd <= n_upd + 1;
  end

  task automatic chk(input string tag, input int obs,
                     input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  // Advance to the negedge following edge k.
  task automatic wait_cyc(input int k);
    int g;
    g = 0;
    while (cyc < k && g < 2000) begin
      @(negedge clk);
      g++;
    end
    chk("wait_cyc", cyc, k);
  endtask

  // One press started on a boundary-aligned cycle p:
  // event at p+18, pending at p+19, duty changes at p+24.
  task automatic press(input string tag, input logic up,
                       input logic dn, input int d_old,
                       input int d_new, input int upd);
    int p;
    p = cyc;
    btn_up = up;
    btn_dn = dn;
    wait_cyc(p + 23);
    chk({tag, "_before"}, int'(duty), d_old);
    wait_cyc(p + 24);
    chk({tag, "_after"}, int'(duty), d_new);
    chk({tag, "_upd"}, int'(duty_upd), upd);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    wait_cyc(p + 48);
  endtask

  // Assert reset between clock edges and check at once.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    chk({tag, "_duty"}, int'(duty), 0);
    chk({tag, "_upd"}, int'(duty_upd), 0);
    chk({tag, "_state"}, int'(dut.r_state), int'(MANUAL));
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_hold"}, int'(duty), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_duty", int'(duty), 0);
    chk("rst_upd", int'(duty_upd), 0);
    chk("rst_state", int'(dut.r_state), int'(MANUAL));

    // Held button: one step at the first boundary after debounce.
    rst = 1'b0;
    btn_up = 1'b1;
    wait_cyc(23);
    chk("hold_pre", int'(duty), 0);
    chk("hold_pre_upd", int'(duty_upd), 0);
    wait_cyc(24);
    chk("hold_step", int'(duty), 1);
    chk("hold_upd", int'(duty_upd), 1);
    wait_cyc(25);
    chk("hold_upd_end", int'(duty_upd), 0);
    wait_cyc(40);
    chk("hold_once", int'(duty), 1);
    chk("hold_npulse", n_upd, 1);
    btn_up = 1'b0;

    // Short glitch is ignored.
    wait_cyc(64);
    btn_up = 1'b1;
    wait_cyc(74);
    btn_up = 1'b0;
    wait_cyc(120);
    chk("glitch_duty", int'(duty), 1);
    chk("glitch_npulse", n_upd, 1);

    // Manual stepping and saturation.
    for (int i = 1; i < 8; i++) begin
      press("up", 1'b1, 1'b0, i, i + 1, 1);
    end
    press("up_sat", 1'b1, 1'b0, 8, 8, 0);
    press("both_max", 1'b1, 1'b1, 8, 8, 0);
    press("dn", 1'b0, 1'b1, 8, 7, 1);
    press("both_mid", 1'b1, 1'b1, 7, 7, 0);

    async_reset("rst_manual");
    rst = 1'b0;

    // Breathe ramp: mode at cycle 8, RISE from edge 11,
    // one step per 32 cycles starting at cycle 40.
    wait_cyc(8);
    snap = n_upd;
    mode = 1'b1;
    wait_cyc(39);
    chk("ramp_pre", int'(duty), 0);
    wait_cyc(40);
    chk("ramp_1", int'(duty), 1);
    chk("ramp_1_upd", int'(duty_upd), 1);
    wait_cyc(41);
    chk("ramp_1_upd_end", int'(duty_upd), 0);
    btn_up = 1'b1;
    wait_cyc(71);
    chk("ramp_press_up", int'(duty), 1);
    btn_up = 1'b0;
    wait_cyc(72);
    chk("ramp_2", int'(duty), 2);
    wait_cyc(263);
    chk("ramp_7", int'(duty), 7);
    wait_cyc(264);
    chk("ramp_top", int'(duty), 8);
    wait_cyc(295);
    chk("ramp_top_hold", int'(duty), 8);
    wait_cyc(296);
    chk("fall_7", int'(duty), 7);
    btn_dn = 1'b1;
    wait_cyc(327);
    chk("fall_press_dn", int'(duty), 7);
    btn_dn = 1'b0;
    wait_cyc(328);
    chk("fall_6", int'(duty), 6);
    wait_cyc(519);
    chk("fall_1", int'(duty), 1);
    wait_cyc(520);
    chk("fall_0", int'(duty), 0);
    chk("fall_0_upd", int'(duty_upd), 1);
    wait_cyc(551);
    chk("bottom_hold", int'(duty), 0);
    wait_cyc(552);
    chk("rise_again", int'(duty), 1);
    wait_cyc(568);
    chk("ramp_npulse", n_upd - snap, 17);
    wait_cyc(616);
    chk("rise_3", int'(duty), 3);

    // Back to manual at duty 3, then one down press.
    wait_cyc(618);
    mode = 1'b0;
    wait_cyc(668);
    chk("manual_hold", int'(duty), 3);
    btn_dn = 1'b1;
    wait_cyc(687);
    chk("manual_dn_pre", int'(duty), 3);
    wait_cyc(688);
    chk("manual_dn", int'(duty), 2);
    chk("manual_dn_upd", int'(duty_upd), 1);
    wait_cyc(698);
    btn_dn = 1'b0;

    // Ramp 2 -> 5, then reset mid-ramp.
    wait_cyc(728);
    mode = 1'b1;
    wait_cyc(824);
    chk("mid_ramp_5", int'(duty), 5);
    wait_cyc(828);
    async_reset("rst_ramp");
    mode = 1'b0;
    rst = 1'b0;
    wait_cyc(64);
    chk("post_rst_duty", int'(duty), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
